// File: rtl/demux_8bit_1para8_reg.sv
// Registered 1-to-8 byte distributor with a per-channel valid/ack hold and valid/ready input.
// Optional auto-increment destination pointer is enabled by defining DEMUX_AUTO_INC_EN.
module demux_8bit_1para8_reg #(
  parameter int             W         = 8,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] D,
  input  logic [2:0]   S,
  input  logic         in_valid,
`ifdef DEMUX_AUTO_INC_EN
  input  logic         auto_md,
`endif
  output logic         in_ready,
  input  logic [7:0]   ack,
  output logic [W-1:0] Y0,
  output logic [W-1:0] Y1,
  output logic [W-1:0] Y2,
  output logic [W-1:0] Y3,
  output logic [W-1:0] Y4,
  output logic [W-1:0] Y5,
  output logic [W-1:0] Y6,
  output logic [W-1:0] Y7,
  output logic [7:0]   vld,
  output logic [2:0]   ptr
);

  logic [W-1:0] y_p1 [8];
  logic [7:0]   vld_p1;
  logic [2:0]   dst;
  logic         accept;
  logic [7:0]   wr_mask;

`ifdef DEMUX_AUTO_INC_EN
  logic [2:0]   ptr_p1;
  assign dst = auto_md ? ptr_p1 : S;
  assign ptr = ptr_p1;
`else
  assign dst = S;
  assign ptr = 3'd0;
`endif

  // A full channel that is being acked this cycle frees its slot in time to accept.
  assign in_ready = ~vld_p1[dst] | ack[dst];
  assign accept   = in_valid & in_ready;
  assign wr_mask  = accept ? (8'd1 << dst) : 8'd0;

  // ---- stage p1: channel holding registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) y_p1[k] <= RESET_VAL;
      vld_p1 <= 8'd0;
    end else begin
      // The write bit is OR-ed in last so a same-cycle write beats an ack.
      vld_p1 <= (vld_p1 & ~ack) | wr_mask;
      if (accept) y_p1[dst] <= D;
    end
  end

`ifdef DEMUX_AUTO_INC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_p1 <= 3'd0;
    end else if (auto_md && accept) begin
      ptr_p1 <= ptr_p1 + 3'd1;
    end
  end
`endif

  assign Y0  = y_p1[0];
  assign Y1  = y_p1[1];
  assign Y2  = y_p1[2];
  assign Y3  = y_p1[3];
  assign Y4  = y_p1[4];
  assign Y5  = y_p1[5];
  assign Y6  = y_p1[6];
  assign Y7  = y_p1[7];
  assign vld = vld_p1;

endmodule

// File: tb/tb_demux_8bit_1para8_reg.sv
// Self-checking bench for demux_8bit_1para8_reg: reference model checked every cycle plus directed literals.
module tb_demux_8bit_1para8_reg;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] D = 8'd0;
  logic [2:0] S = 3'd0;
  logic       in_valid = 1'b0;
  logic       auto_md = 1'b0;
  logic       in_ready;
  logic [7:0] ack = 8'd0;
  logic [7:0] yd [8];
  logic [7:0] vld;
  logic [2:0] ptr;

  int checks = 0;
  int failures = 0;

`ifdef DEMUX_AUTO_INC_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  demux_8bit_1para8_reg dut (
    .clk(clk), .rst(rst), .D(D), .S(S), .in_valid(in_valid),
`ifdef DEMUX_AUTO_INC_EN
    .auto_md(auto_md),
`endif
    .in_ready(in_ready), .ack(ack),
    .Y0(yd[0]), .Y1(yd[1]), .Y2(yd[2]), .Y3(yd[3]),
    .Y4(yd[4]), .Y5(yd[5]), .Y6(yd[6]), .Y7(yd[7]),
    .vld(vld), .ptr(ptr)
  );

  always #5 clk = ~clk;

  // Reference model: eight mailboxes, each holding a byte and a full flag.
  logic [7:0] m_y [8];
  bit         m_full [8];
  int         m_ptr;

  function automatic int m_dst();
    return (AUTO_EN && auto_md) ? m_ptr : int'(S);
  endfunction

  function automatic bit m_ready();
    int d;
    d = m_dst();
    return !m_full[d] || ack[d];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin m_y[k] = 8'h00; m_full[k] = 0; end
      m_ptr = 0;
    end else begin
      int d;
      bit take;
      d = m_dst();
      take = in_valid && m_ready();
      for (int k = 0; k < 8; k++)
        if (ack[k]) m_full[k] = 0;
      if (take) begin
        m_y[d] = D;
        m_full[d] = 1;
        if (AUTO_EN && auto_md) m_ptr = (m_ptr + 1) % 8;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_vld();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_full[k];
    return v;
  endfunction

  // Compare process: outputs are sampled on the falling edge while out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) check($sformatf("model_y%0d", k), 32'(yd[k]), 32'(m_y[k]));
      check("model_vld", 32'(vld), 32'(m_vld()));
      check("model_ptr", 32'(ptr), 32'(m_ptr));
      check("model_in_ready", 32'(in_ready), 32'(m_ready()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [7:0] data);
    S = ch; D = data; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset held over two edges, released just after an edge
    step(); step();
    rst = 1'b0;
    check("rst_vld", 32'(vld), 32'h00);
    check("rst_ptr", 32'(ptr), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_y4", 32'(yd[4]), 32'h00);

    // Addressed write
    wr(3'd5, 8'hA5);
    check("wr_y5", 32'(yd[5]), 32'hA5);
    check("wr_vld", 32'(vld), 32'h20);
    check("wr_y0_untouched", 32'(yd[0]), 32'h00);

    // Backpressure on full channel 3, then same-cycle ack lets the write in
    wr(3'd3, 8'h11);
    S = 3'd3; D = 8'h22; in_valid = 1'b1; ack = 8'h00;
    #1 check("bp_in_ready_low", 32'(in_ready), 32'h0);
    step();
    check("bp_y3_held", 32'(yd[3]), 32'h11);
    ack = 8'h08;
    #1 check("bp_in_ready_ack", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0; ack = 8'h00;
    check("bp_y3_new", 32'(yd[3]), 32'h22);
    check("bp_vld", 32'(vld), 32'h28);

    // Consume everything; data remains
    ack = 8'hFF; step(); ack = 8'h00;
    wr(3'd0, 8'hC3);
    wr(3'd7, 8'h7E);
    check("cons_vld_before", 32'(vld), 32'h81);
    ack = 8'hFF; step(); ack = 8'h00;
    check("cons_vld", 32'(vld), 32'h00);
    check("cons_y0", 32'(yd[0]), 32'hC3);
    check("cons_y7", 32'(yd[7]), 32'h7E);

    // Independent multi-channel acks; ack on empty channel is harmless
    wr(3'd1, 8'h01); wr(3'd2, 8'h02); wr(3'd4, 8'h04);
    ack = 8'h07; step(); ack = 8'h00;
    check("multi_ack_vld", 32'(vld), 32'h10);
    check("empty_ack_y0", 32'(yd[0]), 32'hC3);

    // Full channel 4 without ack: no write, no side effects
    wr(3'd4, 8'h99);
    check("full_y4", 32'(yd[4]), 32'h04);
    check("full_vld", 32'(vld), 32'h10);
    check("full_y5", 32'(yd[5]), 32'hA5);

    // Reset in the middle of a cycle with a transfer pending
    S = 3'd6; D = 8'h5A; in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_vld", 32'(vld), 32'h00);
    check("midrst_y0", 32'(yd[0]), 32'h00);
    check("midrst_y4", 32'(yd[4]), 32'h00);
    check("midrst_ptr", 32'(ptr), 32'h0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_y6_dropped", 32'(yd[6]), 32'h00);
    check("midrst_vld_after", 32'(vld), 32'h00);

`ifdef DEMUX_AUTO_INC_EN
    // Auto mode: advance pointer to 6, then wrap across 7->0
    auto_md = 1'b1;
    for (int i = 0; i < 6; i++) wr(3'd0, 8'(8'h40 + i));
    ack = 8'hFF; step(); ack = 8'h00;
    check("auto_ptr6", 32'(ptr), 32'h6);
    wr(3'd2, 8'h01); wr(3'd2, 8'h02); wr(3'd2, 8'h03);
    check("auto_y6", 32'(yd[6]), 32'h01);
    check("auto_y7", 32'(yd[7]), 32'h02);
    check("auto_y0", 32'(yd[0]), 32'h03);
    check("auto_ptr_wrap", 32'(ptr), 32'h1);

    // Stall on a full target: pointer does not skip
    ack = 8'hFF; step(); ack = 8'h00;
    wr(3'd0, 8'h10);
    auto_md = 1'b0;
    wr(3'd2, 8'h20);
    check("addr_ptr_hold", 32'(ptr), 32'h2);
    auto_md = 1'b1; D = 8'h30; in_valid = 1'b1;
    #1 check("stall_in_ready", 32'(in_ready), 32'h0);
    step(); step();
    check("stall_ptr", 32'(ptr), 32'h2);
    ack = 8'h04; step(); ack = 8'h00; in_valid = 1'b0;
    check("stall_release_ptr", 32'(ptr), 32'h3);
    check("stall_release_y2", 32'(yd[2]), 32'h30);
    auto_md = 1'b0;
`endif

    // A few idle/random-ish cycles exercised only by the model compare
    for (int i = 0; i < 16; i++) begin
      S = 3'(i * 3); D = 8'(i * 17 + 5); in_valid = i[0]; ack = 8'(1 << (i % 8));
      step();
    end
    in_valid = 1'b0; ack = 8'h00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
